vga_sync_gen: RTL and testbench

Pixel-timing generator driving the display side of the game. It produces the pixel tick, the current pixel coordinates (p_x, p_y), the active-low VGA sync pulses and the visible-area flag. The object/score renderer consumes p_tick, p_x and p_y, and returns rgb for the current pixel. A one-cycle end-of-frame strobe lets the game logic update pacman and ghost positions between frames.

---
 rtl/vga_sync_gen_if.sv | 23 ++
 rtl/vga_sync_gen.sv | 76 +++++++
 tb/tb_vga_sync_gen.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// Pixel-timing bundle from the sync generator to the renderer.
// master drives the timing, slave consumes it.
interface vga_sync_gen_if;
    logic       p_tick;
    logic [9:0] p_x;
    logic [9:0] p_y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_end;

    modport master (
        output p_tick, p_x, p_y,
        output hsync, vsync,
        output video_on, frame_end
    );

    modport slave (
        input p_tick, p_x, p_y,
        input hsync, vsync,
        input video_on, frame_end
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA pixel-timing generator: pixel tick, h/v counters, sync pulses,
// visible-area flag and end-of-frame strobe, all registered.
module vga_sync_gen #(
    parameter int TICK_DIV  = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
    localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [TW-1:0] tick_cnt;
    logic          tick_due;
    logic [9:0]    h_nxt;
    logic [9:0]    v_nxt;

    // Position advances at the edge closing a tick cycle, so the
    // decodes below are taken from the position the next cycle shows.
    always_comb begin
        tick_due = (tick_cnt == TICK_LAST);
        h_nxt    = vga.p_x;
        v_nxt    = vga.p_y;
        if (vga.p_tick) begin
            if (vga.p_x == H_LAST) begin
                h_nxt = '0;
                v_nxt = (vga.p_y == V_LAST) ? '0 : vga.p_y + 10'd1;
            end else begin
                h_nxt = vga.p_x + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt      <= '0;
            vga.p_tick    <= 1'b0;
            vga.p_x       <= '0;
            vga.p_y       <= '0;
            vga.hsync     <= 1'b1;
            vga.vsync     <= 1'b1;
            vga.video_on  <= 1'b1;
            vga.frame_end <= 1'b0;
        end else begin
            tick_cnt      <= tick_due ? '0 : tick_cnt + TICK_ONE;
            vga.p_tick    <= tick_due;
            vga.p_x       <= h_nxt;
            vga.p_y       <= v_nxt;
            vga.hsync     <= !(h_nxt >= HS_BEG && h_nxt < HS_END);
            vga.vsync     <= !(v_nxt >= VS_BEG && v_nxt < VS_END);
            vga.video_on  <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
            vga.frame_end <= tick_due && (h_nxt == H_LAST)
                             && (v_nxt == V_LAST);
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two small-geometry instances (divide 4 and 1)
// against an arithmetic timing model, plus per-frame totals.
module tb_vga_sync_gen;
    localparam int HD = 10, HF = 2, HS = 3, HB = 2;
    localparam int VD = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int DA = 4;
    localparam int DB = 1;
    localparam int FRAME_A = HT * VT * DA;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fe;
    } obs_t;

    typedef struct packed {
        logic r;
        obs_t a;
        obs_t b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;
    int   k = 0;
    exp_t sb[$];

    vga_sync_gen_if ifa ();
    vga_sync_gen_if ifb ();

    vga_sync_gen #(
        .TICK_DIV(DA), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS),
        .H_BACK(HB), .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS),
        .V_BACK(VB)
    ) dut_a (.clk(clk), .rst(rst), .vga(ifa.master));

    vga_sync_gen #(
        .TICK_DIV(DB), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS),
        .H_BACK(HB), .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS),
        .V_BACK(VB)
    ) dut_b (.clk(clk), .rst(rst), .vga(ifb.master));

    always #5 clk = ~clk;

    // k = clk edges since the last reset edge; ticks land on multiples of d
    function automatic obs_t model(int kk, int d);
        obs_t o;
        int pos, h, v;
        o.p_tick = (kk > 0) && (kk % d == 0);
        pos = (kk == 0) ? 0 : ((kk - 1) / d) % (HT * VT);
        h = pos % HT;
        v = pos / HT;
        o.x   = 10'(h);
        o.y   = 10'(v);
        o.hs  = !(h >= HD + HF && h < HD + HF + HS);
        o.vs  = !(v >= VD + VF && v < VD + VF + VS);
        o.von = (h < HD) && (v < VD);
        o.fe  = o.p_tick && (h == HT - 1) && (v == VT - 1);
        return o;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t actual=%h required=%h",
                     nm, $time, act, exp);
        end
    endtask

    task automatic step(logic r);
        exp_t e;
        rst = r;
        @(posedge clk);
        #1;
        if (r) k = 0;
        else k++;
        e.r = r;
        e.a = model(k, DA);
        e.b = model(k, DB);
        sb.push_back(e);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic pulse_rst(int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    // per-frame totals, taken from what the DUT presented under p_tick
    int ticks [2];
    int vid   [2];
    int hsl   [2];
    int vsl   [2];
    int cov   [2][VD*HD];

    task automatic clr_frame(int i);
        ticks[i] = 0;
        vid[i] = 0;
        hsl[i] = 0;
        vsl[i] = 0;
        for (int j = 0; j < VD * HD; j++) cov[i][j] = 0;
    endtask

    task automatic frame_acc(int i, obs_t o);
        int bad;
        if (!o.p_tick) return;
        ticks[i]++;
        if (!o.hs) hsl[i]++;
        if (!o.vs) vsl[i]++;
        if (o.von) begin
            vid[i]++;
            if (o.x < 10'(HD) && o.y < 10'(VD))
                cov[i][int'(o.y) * HD + int'(o.x)]++;
        end
        if (o.fe) begin
            bad = 0;
            for (int j = 0; j < VD * HD; j++)
                if (cov[i][j] != 1) bad++;
            chk($sformatf("frame_ticks%0d", i), ticks[i], HT * VT);
            chk($sformatf("frame_video%0d", i), vid[i], HD * VD);
            chk($sformatf("frame_hsync%0d", i), hsl[i], HS * VT);
            chk($sformatf("frame_vsync%0d", i), vsl[i], VS * HT);
            chk($sformatf("frame_cover%0d", i), bad, 0);
            clr_frame(i);
        end
    endtask

    initial begin : monitor
        exp_t e;
        obs_t oa, ob;
        clr_frame(0);
        clr_frame(1);
        @(posedge clk);
        forever begin
            @(negedge clk);
            oa = {ifa.p_tick, ifa.p_x, ifa.p_y, ifa.hsync,
                  ifa.vsync, ifa.video_on, ifa.frame_end};
            ob = {ifb.p_tick, ifb.p_x, ifb.p_y, ifb.hsync,
                  ifb.vsync, ifb.video_on, ifb.frame_end};
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("div4_outputs", 32'(oa), 32'(e.a));
                chk("div1_outputs", 32'(ob), 32'(e.b));
                if (e.r) begin
                    clr_frame(0);
                    clr_frame(1);
                end
                frame_acc(0, oa);
                frame_acc(1, ob);
            end
        end
    end

    initial begin : stim
        pulse_rst(3);
        run(2 * FRAME_A + 20);
        pulse_rst(2);
        // stop partway into a tick at (7,5), hold reset 3 clks
        run(DA * (5 * HT + 7) + 2);
        pulse_rst(3);
        run(3 * FRAME_A);
        for (int i = 0; i < 12; i++) begin
            run(int'($urandom_range(1, 900)));
            pulse_rst(int'($urandom_range(1, 3)));
        end
        run(2 * FRAME_A + 5);
        @(negedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
